// File: rtl/mac_host_driver.sv
// mac_host_driver: loads weight/data matrices, streams them to the MAC array, collects N*N results.
// Latency: first weight beat is visible 2 cycles after start_i is accepted; all mac_* outputs are registered.
// Backpressure: none toward the array (one beat per enabled cycle); ena low freezes the FSM, counters and capture.
//
// Ports:
//   clk, rst (synchronous, active-high), ena (global enable)
//   cfg_wr_i, cfg_sel_i, cfg_addr_i, cfg_data_i : weight (sel=0) / data (sel=1) buffer write, ignored while busy
//   start_i, busy_o, done_o, err_o              : transfer launch and status
//   rd_addr_i, rd_data_o                        : combinational result buffer read
//   mac_data_v_o, mac_data_mode_o, mac_data_rst_addr_o, mac_data_o : beat stream toward the array
//   mac_result_v_i, mac_result_i                : result beats returned by the array
module mac_host_driver #(
  parameter int W       = 8,
  parameter int N       = 2,
  parameter int GAP     = 0,
  parameter int TIMEOUT = 64,
  localparam int NN     = N * N,
  localparam int AW     = (NN > 1) ? $clog2(NN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          cfg_wr_i,
  input  logic          cfg_sel_i,
  input  logic [AW-1:0] cfg_addr_i,
  input  logic [W-1:0]  cfg_data_i,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_data_o,
  output logic          mac_data_v_o,
  output logic          mac_data_mode_o,
  output logic          mac_data_rst_addr_o,
  output logic [W-1:0]  mac_data_o,
  input  logic          mac_result_v_i,
  input  logic [W-1:0]  mac_result_i
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [AW-1:0] LAST_IDX = AW'(NN - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(N - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(NN);
  localparam logic [AW:0]   CNT_LAST = (AW + 1)'(NN - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0]    GAP_LD   = 4'(GAP);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_W = 3'd1,
    SEND_D = 3'd2,
    WAIT_R = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  idx_q, idx_d;          // beat index within the current burst
  logic [CW-1:0]  col_q, col_d;          // column within the current data row
  logic [3:0]     gap_q, gap_d;          // idle cycles still owed after a data row
  logic [TW-1:0]  timer_q, timer_d;      // enabled cycles spent in WAIT_R
  logic [AW:0]    res_cnt_q, res_cnt_d;  // results captured so far (0..NN)
  logic           err_q, err_d;

  logic           v_q, v_d;
  logic           mode_q, mode_d;
  logic           rst_addr_q, rst_addr_d;
  logic [W-1:0]   dat_q, dat_d;

  logic [W-1:0]   wbuf_q [NN];
  logic [W-1:0]   wbuf_d [NN];
  logic [W-1:0]   dbuf_q [NN];
  logic [W-1:0]   dbuf_d [NN];
  logic [W-1:0]   rbuf_q [NN];
  logic [W-1:0]   rbuf_d [NN];

  logic           in_xfer;
  logic           cap;
  logic           all_done;
  logic           tmo;
  logic           beat_slot;

  assign in_xfer   = (state_q == SEND_W) || (state_q == SEND_D) || (state_q == WAIT_R);
  assign cap       = ena && in_xfer && mac_result_v_i;
  // Completion counts a result landing this very cycle, so the FSM can leave on the next edge.
  assign all_done  = (res_cnt_q == CNT_FULL) || (cap && (res_cnt_q == CNT_LAST));
  assign tmo       = (timer_q == TMO_LAST);
  assign beat_slot = (gap_q == 4'd0);

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      col_q      <= '0;
      gap_q      <= '0;
      timer_q    <= '0;
      res_cnt_q  <= '0;
      err_q      <= 1'b0;
      v_q        <= 1'b0;
      mode_q     <= 1'b0;
      rst_addr_q <= 1'b0;
      dat_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      col_q      <= col_d;
      gap_q      <= gap_d;
      timer_q    <= timer_d;
      res_cnt_q  <= res_cnt_d;
      err_q      <= err_d;
      v_q        <= v_d;
      mode_q     <= mode_d;
      rst_addr_q <= rst_addr_d;
      dat_q      <= dat_d;
    end
  end

  // Buffer storage carries no reset; contents survive rst.
  always_ff @(posedge clk) begin
    wbuf_q <= wbuf_d;
    dbuf_q <= dbuf_d;
    rbuf_q <= rbuf_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (ena) begin
      case (state_q)
        IDLE:    if (start_i) state_d = SEND_W;
        SEND_W:  if (idx_q == LAST_IDX) state_d = SEND_D;
        SEND_D:  if (beat_slot && (idx_q == LAST_IDX)) state_d = all_done ? DONE : WAIT_R;
        WAIT_R:  if (all_done || tmo) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath, beat generation and result capture.
  always_comb begin
    idx_d      = idx_q;
    col_d      = col_q;
    gap_d      = gap_q;
    res_cnt_d  = res_cnt_q;
    err_d      = err_q;
    v_d        = 1'b0;
    mode_d     = mode_q;
    rst_addr_d = 1'b0;
    dat_d      = dat_q;
    wbuf_d     = wbuf_q;
    dbuf_d     = dbuf_q;
    rbuf_d     = rbuf_q;

    // The timer only runs inside WAIT_R, so it always starts from zero on entry.
    if (state_q != WAIT_R) begin
      timer_d = '0;
    end else if (ena) begin
      timer_d = timer_q + 1'b1;
    end else begin
      timer_d = timer_q;
    end

    // Buffers are frozen during a transfer; an IDLE write beside start_i still lands
    // and is picked up because SEND_W reads the buffer a cycle later.
    if (cfg_wr_i && !in_xfer) begin
      if (cfg_sel_i) begin
        dbuf_d[cfg_addr_i] = cfg_data_i;
      end else begin
        wbuf_d[cfg_addr_i] = cfg_data_i;
      end
    end

    if (ena) begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            idx_d     = '0;
            col_d     = '0;
            gap_d     = '0;
            res_cnt_d = '0;
            err_d     = 1'b0;
          end
        end
        SEND_W: begin
          v_d        = 1'b1;
          mode_d     = 1'b1;
          rst_addr_d = (idx_q == '0);
          dat_d      = wbuf_q[idx_q];
          idx_d      = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
        SEND_D: begin
          if (!beat_slot) begin
            gap_d = gap_q - 4'd1;
          end else begin
            v_d        = 1'b1;
            mode_d     = 1'b0;
            rst_addr_d = (idx_q == '0);
            dat_d      = dbuf_q[idx_q];
            idx_d      = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            if (col_q == LAST_COL) begin
              col_d = '0;
              // No gap after the final row.
              if (idx_q != LAST_IDX) gap_d = GAP_LD;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
        WAIT_R: begin
          if (tmo && !all_done) err_d = 1'b1;
        end
        default: begin
        end
      endcase
    end

    if (cap) begin
      if (res_cnt_q < CNT_FULL) begin
        rbuf_d[res_cnt_q[AW-1:0]] = mac_result_i;
        res_cnt_d                 = res_cnt_q + 1'b1;
      end else begin
        // Surplus beat: dropped, flagged.
        err_d = 1'b1;
      end
    end
  end

  // Outputs.
  always_comb begin
    busy_o              = in_xfer;
    done_o              = (state_q == DONE);
    err_o               = err_q;
    rd_data_o           = rbuf_q[rd_addr_i];
    mac_data_v_o        = v_q;
    mac_data_mode_o     = mode_q;
    mac_data_rst_addr_o = rst_addr_q;
    mac_data_o          = dat_q;
  end

endmodule
